// File: rtl/bless_port_alloc_pkg.sv
// Shared flit layout, port numbering and helpers
// for the BLESS output-port allocation stage.
package bless_port_alloc_pkg;

  localparam int CONTROL_W = 16;
  localparam int DATA_W    = 32;
  localparam int COORD_W   = 4;

  localparam int VALID_F   = 15;
  localparam int GOLD_F    = 14;
  localparam int SEQ_HI    = 13;
  localparam int SEQ_LO    = 8;
  localparam int DESTX_HI  = 7;
  localparam int DESTX_LO  = 4;
  localparam int DESTY_HI  = 3;
  localparam int DESTY_LO  = 0;

  localparam logic [1:0] PORT_N = 2'd0;
  localparam logic [1:0] PORT_E = 2'd1;
  localparam logic [1:0] PORT_S = 2'd2;
  localparam logic [1:0] PORT_W = 2'd3;

  typedef logic [CONTROL_W-1:0] ctrl_t;
  typedef logic [DATA_W-1:0]    data_t;
  typedef logic [COORD_W-1:0]   coord_t;

  typedef struct packed {
    logic       defl;
    logic [1:0] port;
  } pick_t;

  function automatic logic [1:0] pref_port(input int k);
    logic [1:0] p;
    unique case (k)
      0:       p = PORT_E;
      1:       p = PORT_W;
      2:       p = PORT_N;
      default: p = PORT_S;
    endcase
    return p;
  endfunction

  // Productive ports in E,W,N,S order first,
  // else the lowest-numbered free port.
  function automatic pick_t pick_port(
    input logic [3:0] prod,
    input logic [3:0] used
  );
    pick_t      r;
    logic [1:0] q;
    r = '{defl: 1'b1, port: PORT_N};
    for (int i = 3; i >= 0; i--)
      if (!used[i]) r.port = 2'(i);
    for (int k = 3; k >= 0; k--) begin
      q = pref_port(k);
      if (prod[q] && !used[q])
        r = '{defl: 1'b0, port: q};
    end
    return r;
  endfunction

endpackage

// File: rtl/bless_port_alloc_if.sv
// Flit, priority and status bundle between
// the comparator side and the allocator.
interface bless_port_alloc_if #(
  parameter int CNT_W = 16
);
  import bless_port_alloc_pkg::*;

  ctrl_t control0, control1;
  ctrl_t control2, control3;
  data_t data0, data1, data2, data3;
  logic [1:0] priority0, priority1;
  logic [1:0] priority2, priority3;
  logic [1:0] rr;
  ctrl_t out_control0, out_control1;
  ctrl_t out_control2, out_control3;
  data_t out_data0, out_data1;
  data_t out_data2, out_data3;
  logic  eject_valid;
  ctrl_t eject_control;
  data_t eject_data;
  logic [CNT_W-1:0] deflect_cnt;

  modport master (
    output control0, control1,
    output control2, control3,
    output data0, data1, data2, data3,
    output priority0, priority1,
    output priority2, priority3,
    input  rr,
    input  out_control0, out_control1,
    input  out_control2, out_control3,
    input  out_data0, out_data1,
    input  out_data2, out_data3,
    input  eject_valid, eject_control,
    input  eject_data, deflect_cnt
  );

  modport slave (
    input  control0, control1,
    input  control2, control3,
    input  data0, data1, data2, data3,
    input  priority0, priority1,
    input  priority2, priority3,
    output rr,
    output out_control0, out_control1,
    output out_control2, out_control3,
    output out_data0, out_data1,
    output out_data2, out_data3,
    output eject_valid, eject_control,
    output eject_data, deflect_cnt
  );

endinterface

// File: rtl/bless_port_alloc_route_calc.sv
// Productive-direction mask and local flag
// for one flit relative to this router.
module bless_route_calc
  import bless_port_alloc_pkg::*;
(
  input  ctrl_t      ctrl_i,
  input  coord_t     x_i,
  input  coord_t     y_i,
  output logic [3:0] prod_o,
  output logic       local_o
);

  logic signed [COORD_W:0] dx;
  logic signed [COORD_W:0] dy;
  logic unused_bits;

  assign dx = $signed({1'b0, ctrl_i[DESTX_HI:DESTX_LO]})
            - $signed({1'b0, x_i});
  assign dy = $signed({1'b0, ctrl_i[DESTY_HI:DESTY_LO]})
            - $signed({1'b0, y_i});

  assign unused_bits = ^ctrl_i[GOLD_F:SEQ_LO];

  always_comb begin
    prod_o         = '0;
    prod_o[PORT_E] = dx > 0;
    prod_o[PORT_W] = dx < 0;
    prod_o[PORT_N] = dy > 0;
    prod_o[PORT_S] = dy < 0;
  end

  assign local_o = ctrl_i[VALID_F]
                && (dx == 0) && (dy == 0);

endmodule

// File: rtl/bless_port_alloc.sv
// BLESS output-port allocation: one eject slot,
// priority-ordered port chain, rr and stats.
module bless_port_alloc
  import bless_port_alloc_pkg::*;
#(
  parameter int X_COORD = 0,
  parameter int Y_COORD = 0,
  parameter int CNT_W   = 16
) (
  input logic clk,
  input logic rst_n,
  bless_port_alloc_if.slave bus
);

  localparam coord_t XC = COORD_W'(X_COORD);
  localparam coord_t YC = COORD_W'(Y_COORD);
  localparam int SW = (CNT_W > 3) ? CNT_W + 1 : 4;
  localparam logic [SW-1:0] CMAX =
    SW'({CNT_W{1'b1}});

  ctrl_t      ctrl [4];
  data_t      data [4];
  logic [1:0] prio [4];
  logic [3:0] prod [4];
  logic [3:0] is_local;

  assign ctrl = '{bus.control0, bus.control1,
                  bus.control2, bus.control3};
  assign data = '{bus.data0, bus.data1,
                  bus.data2, bus.data3};
  assign prio = '{bus.priority0, bus.priority1,
                  bus.priority2, bus.priority3};

  for (genvar i = 0; i < 4; i++) begin : g_rc
    bless_route_calc u_rc (
      .ctrl_i  (ctrl[i]),
      .x_i     (XC),
      .y_i     (YC),
      .prod_o  (prod[i]),
      .local_o (is_local[i])
    );
  end

  ctrl_t      out_ctrl_d [4];
  data_t      out_data_d [4];
  ctrl_t      out_ctrl_q [4];
  data_t      out_data_q [4];
  logic       ej_valid_d, ej_valid_q;
  ctrl_t      ej_ctrl_d, ej_ctrl_q;
  data_t      ej_data_d, ej_data_q;
  logic [2:0] defl_d;
  logic [3:0] used;
  logic [1:0] src;
  pick_t      pk;
  logic [1:0] rr_d, rr_q;
  logic [SW-1:0]    sum;
  logic [CNT_W-1:0] cnt_d, cnt_q;

  // Earlier ranks claim ports first; the first
  // local flit takes the single eject slot.
  always_comb begin
    used       = '0;
    src        = '0;
    pk         = '0;
    ej_valid_d = 1'b0;
    ej_ctrl_d  = '0;
    ej_data_d  = '0;
    defl_d     = '0;
    for (int p = 0; p < 4; p++) begin
      out_ctrl_d[p] = '0;
      out_data_d[p] = '0;
    end
    for (int r = 0; r < 4; r++) begin
      src = prio[r];
      if (ctrl[src][VALID_F]) begin
        if (is_local[src] && !ej_valid_d) begin
          ej_valid_d = 1'b1;
          ej_ctrl_d  = ctrl[src];
          ej_data_d  = data[src];
        end else begin
          pk = pick_port(prod[src], used);
          used[pk.port]       = 1'b1;
          out_ctrl_d[pk.port] = ctrl[src];
          out_data_d[pk.port] = data[src];
          defl_d = defl_d + 3'(pk.defl);
        end
      end
    end
  end

  assign rr_d  = rr_q + 2'd1;
  assign sum   = SW'(cnt_q) + SW'(defl_d);
  assign cnt_d = (sum > CMAX) ? {CNT_W{1'b1}}
                              : sum[CNT_W-1:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int p = 0; p < 4; p++) begin
        out_ctrl_q[p] <= '0;
        out_data_q[p] <= '0;
      end
      ej_valid_q <= 1'b0;
      ej_ctrl_q  <= '0;
      ej_data_q  <= '0;
      rr_q       <= '0;
      cnt_q      <= '0;
    end else begin
      for (int p = 0; p < 4; p++) begin
        out_ctrl_q[p] <= out_ctrl_d[p];
        out_data_q[p] <= out_data_d[p];
      end
      ej_valid_q <= ej_valid_d;
      ej_ctrl_q  <= ej_ctrl_d;
      ej_data_q  <= ej_data_d;
      rr_q       <= rr_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus.out_control0  = out_ctrl_q[0];
  assign bus.out_control1  = out_ctrl_q[1];
  assign bus.out_control2  = out_ctrl_q[2];
  assign bus.out_control3  = out_ctrl_q[3];
  assign bus.out_data0     = out_data_q[0];
  assign bus.out_data1     = out_data_q[1];
  assign bus.out_data2     = out_data_q[2];
  assign bus.out_data3     = out_data_q[3];
  assign bus.eject_valid   = ej_valid_q;
  assign bus.eject_control = ej_ctrl_q;
  assign bus.eject_data    = ej_data_q;
  assign bus.rr            = rr_q;
  assign bus.deflect_cnt   = cnt_q;

endmodule
